// File: rtl/peach_lsu_if.sv
// Core-request and data-memory signals of the peach32 load/store unit.
// master: the core plus data memory; slave: the LSU.
interface peach_lsu_if;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err_misalign;
  logic        err_timeout;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output start, is_store, funct3, addr, wdata, mem_rdata, mem_ack,
    input  busy, done, rdata, err_misalign, err_timeout,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  start, is_store, funct3, addr, wdata, mem_rdata, mem_ack,
    output busy, done, rdata, err_misalign, err_timeout,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/peach_lsu.sv
// peach32 load/store unit: alignment check, byte-lane memory access, load extension.
// Optional memory timeout abort enabled by defining PEACH_LSU_TIMEOUT_EN.
module peach_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       reset,
  peach_lsu_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StFault, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_mis_q;
  logic        accept;
  logic        req_fault;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        to_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign accept = (state_q == StIdle) && bus.start;

  // Request decode on the live inputs; funct3[1:0] is the access size.
  always_comb begin
    req_fault = 1'b0;
    req_be    = 4'b1111;
    req_wdata = bus.wdata;
    if (bus.is_store) begin
      if (bus.funct3 > 3'd2) req_fault = 1'b1;
    end else if (bus.funct3 == 3'd3 || bus.funct3 > 3'd5) begin
      req_fault = 1'b1;
    end
    unique case (bus.funct3[1:0])
      2'd0: begin
        req_be    = 4'b0001 << bus.addr[1:0];
        req_wdata = {4{bus.wdata[7:0]}};
      end
      2'd1: begin
        req_be    = bus.addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{bus.wdata[15:0]}};
        if (bus.addr[0]) req_fault = 1'b1;
      end
      2'd2: begin
        if (bus.addr[1:0] != 2'b00) req_fault = 1'b1;
      end
      default: ;
    endcase
    if (!bus.is_store) req_wdata = '0;
  end

  always_comb begin
    ld_byte = bus.mem_rdata[8*addr_q[1:0] +: 8];
    ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'h0, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'h0, ld_half};
      default: ld_ext = bus.mem_rdata;
    endcase
  end

`ifdef PEACH_LSU_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q;
  logic            err_to_q;

  // Fires in the cycle whose unacknowledged request would make the count reach the limit.
  assign to_hit = (state_q == StAccess) && !bus.mem_ack &&
                  (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      err_to_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= '0;
        err_to_q <= 1'b0;
      end else if (state_q == StAccess && !bus.mem_ack) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (to_hit) err_to_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start) state_d = req_fault ? StFault : StAccess;
      StAccess: if (bus.mem_ack || to_hit) state_d = StResp;
      StFault:  state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      f3_q      <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_mis_q <= 1'b0;
    end else begin
      if (accept) begin
        we_q      <= bus.is_store;
        addr_q    <= bus.addr;
        f3_q      <= bus.funct3;
        be_q      <= req_be;
        wdata_q   <= req_wdata;
        rdata_q   <= '0;
        err_mis_q <= 1'b0;
      end
      if (state_q == StAccess && bus.mem_ack && !we_q) rdata_q <= ld_ext;
      if (state_q == StFault) err_mis_q <= 1'b1;
    end
  end

  always_comb begin
    bus.busy         = (state_q == StAccess) || (state_q == StFault);
    bus.done         = (state_q == StResp);
    bus.rdata        = rdata_q;
    bus.err_misalign = err_mis_q;
`ifdef PEACH_LSU_TIMEOUT_EN
    bus.err_timeout  = err_to_q;
`else
    bus.err_timeout  = 1'b0;
`endif
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_be       = '0;
    bus.mem_wdata    = '0;
    if (state_q == StAccess) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we_q;
      bus.mem_addr  = {addr_q[31:2], 2'b00};
      bus.mem_be    = be_q;
      bus.mem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_peach_lsu.sv
// Randomised and directed bench for peach_lsu against an arithmetic reference model.
module tb_peach_lsu;
`ifdef PEACH_LSU_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  peach_lsu_if bus ();

  peach_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; dly = mem_req cycles before ack (0 = never ack).
  task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rw, input int dly,
                     input bit noisy);
    bit          fault, tmo, seen;
    int          size, off, reqc, cyc, exp_reqc;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, b, h;
    size  = int'(f3 % 4);
    off   = int'(a % 4);
    fault = st ? (f3 > 2) : (f3 == 3 || f3 > 5);
    if (size == 1 && off % 2 == 1) fault = 1;
    if (size == 2 && off != 0) fault = 1;
    e_be = (size == 0) ? 4'(1 << off) : (size == 1) ? ((off >= 2) ? 4'hC : 4'h3) : 4'hF;
    e_wd = !st ? 32'h0 : (size == 0) ? (wd % 256) * 32'h01010101 :
           (size == 1) ? (wd % 65536) * 32'h00010001 : wd;
    b = (rw >> (8 * off)) % 256;
    h = (rw >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    e_rd = (b >= 128) ? b - 256 : b;
      3'd4:    e_rd = b;
      3'd1:    e_rd = (h >= 32768) ? h - 65536 : h;
      3'd5:    e_rd = h;
      default: e_rd = rw;
    endcase
`ifdef PEACH_LSU_TIMEOUT_EN
    tmo = !fault && (dly == 0 || dly > int'(TO));
`else
    tmo = 0;
`endif
    if (st || fault || tmo) e_rd = 0;
    exp_reqc = fault ? 0 : tmo ? int'(TO) : dly;

    @(negedge clk);
    bus.start = 1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    bus.start = 0;
    reqc = 0; cyc = 1; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin seen = 1; break; end
      if (bus.mem_req) begin
        reqc++;
        if (reqc == 1) begin
          chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
          chk("mem_be", 32'(bus.mem_be), 32'(e_be));
          chk("mem_we", 32'(bus.mem_we), 32'(st));
          chk("mem_wdata", bus.mem_wdata, e_wd);
          chk("busy_access", 32'(bus.busy), 1);
        end
        bus.mem_ack   = (reqc == dly);
        bus.mem_rdata = (reqc == dly) ? rw : $urandom;
      end else begin
        bus.mem_ack   = $urandom_range(0, 1);
        bus.mem_rdata = $urandom;
      end
      if (noisy) bus.start = $urandom_range(0, 1);
      @(negedge clk);
      cyc++;
    end
    bus.start = 0; bus.mem_ack = 0;
    chk("done_seen", 32'(seen), 1);
    chk("latency", cyc, fault ? 2 : exp_reqc + 1);
    chk("req_cycles", reqc, exp_reqc);
    chk("rdata", bus.rdata, e_rd);
    chk("err_misalign", 32'(bus.err_misalign), 32'(fault));
    chk("err_timeout", 32'(bus.err_timeout), 32'(tmo));
    chk("busy_at_done", 32'(bus.busy), 0);
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 0);
    chk("rdata_held", bus.rdata, e_rd);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          dly;
    bus.start = 0; bus.is_store = 0; bus.funct3 = 0; bus.addr = 0; bus.wdata = 0;
    bus.mem_rdata = 0; bus.mem_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_be", 32'(bus.mem_be), 0);
    reset = 0;

    txn(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0);
    txn(0, 3'd0, 32'h103, 32'h0, 32'h80123456, 1, 0);
    txn(0, 3'd4, 32'h103, 32'h0, 32'h80123456, 2, 0);
    txn(1, 3'd1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 1, 0);
    txn(0, 3'd2, 32'h101, 32'h0, 32'h0, 1, 0);
    txn(1, 3'd5, 32'h200, 32'h0, 32'h0, 1, 0);
    txn(0, 3'd5, 32'h102, 32'h0, 32'h9ABC1234, 1, 0);

    // Reset in the middle of a store access.
    @(negedge clk);
    bus.start = 1; bus.is_store = 1; bus.funct3 = 3'd2; bus.addr = 32'h300;
    bus.wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.start = 0;
    chk("sw_req_up", 32'(bus.mem_req), 1);
    #2 reset = 1;
    #1;
    chk("rst_mid_req", 32'(bus.mem_req), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_done", 32'(bus.done), 0);
    @(negedge clk);
    reset = 0;
    txn(0, 3'd2, 32'h400, 32'h0, 32'h13572468, 2, 1);

`ifdef PEACH_LSU_TIMEOUT_EN
    txn(0, 3'd2, 32'h500, 32'h0, 32'h11112222, 0, 0);
    txn(0, 3'd2, 32'h504, 32'h0, 32'h33334444, 4, 0);
    txn(1, 3'd0, 32'h507, 32'h5A, 32'h0, 5, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'd0) ? a[1:0] :
                                              (f3[1:0] == 2'd1) ? {a[1], 1'b0} : 2'b00;
`ifdef PEACH_LSU_TIMEOUT_EN
      dly = $urandom_range(0, 6);
`else
      dly = $urandom_range(1, 6);
`endif
      txn(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, dly, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
